rv_iopmp_tl_arbiter: RTL and testbench

//  Shares one rv_iopmp_transaction_logic instance between NUM_REQ requesters (e.g. AR/AW channels of

---
 rtl/rv_iopmp_tl_arbiter_if.sv | 65 ++++++
 rtl/rv_iopmp_tl_arbiter.sv | 145 ++++++++++++++
 tb/tb_rv_iopmp_tl_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_iopmp_tl_arbiter_if.sv
// Access-type package plus the requester-side and TL-side bundles of the
// shared transaction-logic arbiter.
package rv_iopmp_pkg;
    typedef enum logic [2:0] {
        ACCESS_NONE    = 3'd0,
        ACCESS_READ    = 3'd1,
        ACCESS_WRITE   = 3'd2,
        ACCESS_EXECUTE = 3'd4
    } access_t;
endpackage

interface rv_iopmp_arb_req_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SID_WIDTH  = 8
);
    localparam int NB = $clog2(DATA_WIDTH / 8) + 1;

    logic [NUM_REQ-1:0]                    req_valid_i;
    logic [NUM_REQ-1:0]                    req_ready_o;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr_i;
    logic [NUM_REQ-1:0][NB-1:0]            req_num_bytes_i;
    logic [NUM_REQ-1:0][SID_WIDTH-1:0]     req_sid_i;
    rv_iopmp_pkg::access_t [NUM_REQ-1:0]   req_access_i;
    logic [NUM_REQ-1:0]                    rsp_valid_o;
    logic                                  rsp_allow_o;

    // slave = arbiter side, master = requester side
    modport slave (
        input  req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
        output req_ready_o, rsp_valid_o, rsp_allow_o
    );
    modport master (
        output req_valid_i, req_addr_i, req_num_bytes_i, req_sid_i, req_access_i,
        input  req_ready_o, rsp_valid_o, rsp_allow_o
    );
endinterface

interface rv_iopmp_arb_tl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SID_WIDTH  = 8
);
    localparam int NB = $clog2(DATA_WIDTH / 8) + 1;

    logic                  tl_transaction_en_o;
    logic [ADDR_WIDTH-1:0] tl_addr_o;
    logic [NB-1:0]         tl_num_bytes_o;
    logic [SID_WIDTH-1:0]  tl_sid_o;
    rv_iopmp_pkg::access_t tl_access_o;
    logic                  tl_ready_i;
    logic                  tl_valid_i;
    logic                  tl_allow_i;

    // master = arbiter side, slave = transaction-logic side
    modport master (
        output tl_transaction_en_o, tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_o,
        input  tl_ready_i, tl_valid_i, tl_allow_i
    );
    modport slave (
        input  tl_transaction_en_o, tl_addr_o, tl_num_bytes_o, tl_sid_o, tl_access_o,
        output tl_ready_i, tl_valid_i, tl_allow_i
    );
endinterface

// File: rtl/rv_iopmp_tl_arbiter.sv
// Round-robin arbiter sharing one IOPMP transaction-logic checker between
// NUM_REQ requesters, one check in flight, with a deny-on-timeout watchdog.
module rv_iopmp_tl_arbiter
    import rv_iopmp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SID_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv_iopmp_arb_req_if.slave  req,
    rv_iopmp_arb_tl_if.master  tl,
    output logic               busy_o,
    output logic               timeout_o
);
    localparam int NB = $clog2(DATA_WIDTH / 8) + 1;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [GW-1:0]         last_q, last_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB-1:0]         nb_q, nb_d;
    logic [SID_WIDTH-1:0]  sid_q, sid_d;
    access_t               acc_q, acc_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  allow_q, allow_d;
    logic                  to_q, to_d;

    logic [GW-1:0]         gnt_sel;
    logic                  gnt_found;
    logic                  any_req;
    logic                  wd_fire;

    assign any_req = |req.req_valid_i;
    assign wd_fire = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        gnt_sel   = last_q;
        gnt_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!gnt_found && req.req_valid_i[(int'(last_q) + k) % NUM_REQ]) begin
                gnt_sel   = GW'((int'(last_q) + k) % NUM_REQ);
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        nb_d    = nb_q;
        sid_d   = sid_q;
        acc_d   = acc_q;
        timer_d = timer_q;
        allow_d = allow_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = gnt_sel;
                    addr_d  = req.req_addr_i[gnt_sel];
                    nb_d    = req.req_num_bytes_i[gnt_sel];
                    sid_d   = req.req_sid_i[gnt_sel];
                    acc_d   = req.req_access_i[gnt_sel];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (tl.tl_ready_i) begin
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real verdict beats the watchdog when both land together.
                if (tl.tl_valid_i) begin
                    allow_d = tl.tl_allow_i;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (wd_fire) begin
                    allow_d = 1'b0;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= GW'(NUM_REQ - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            nb_q    <= '0;
            sid_q   <= '0;
            acc_q   <= ACCESS_NONE;
            timer_q <= '0;
            allow_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            nb_q    <= nb_d;
            sid_q   <= sid_d;
            acc_q   <= acc_d;
            timer_q <= timer_d;
            allow_q <= allow_d;
            to_q    <= to_d;
        end
    end

    // Verdict outputs are gated by RESP so they read 0 outside the pulse.
    assign req.req_ready_o     = (state_q == IDLE && any_req) ? (ONE << gnt_sel) : '0;
    assign req.rsp_valid_o     = (state_q == RESP) ? (ONE << gnt_q) : '0;
    assign req.rsp_allow_o     = (state_q == RESP) && allow_q;
    assign timeout_o           = (state_q == RESP) && to_q;
    assign busy_o              = (state_q != IDLE);

    assign tl.tl_transaction_en_o = (state_q == ISSUE);
    assign tl.tl_addr_o           = addr_q;
    assign tl.tl_num_bytes_o      = nb_q;
    assign tl.tl_sid_o            = sid_q;
    assign tl.tl_access_o         = acc_q;
endmodule

// File: tb/tb_rv_iopmp_tl_arbiter.sv
// Directed bench for rv_iopmp_tl_arbiter: grant order, ISSUE hold, verdicts,
// watchdog timing and mid-transaction reset.
module tb_rv_iopmp_tl_arbiter;
    import rv_iopmp_pkg::*;

    localparam int NR = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, tmo;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv_iopmp_arb_req_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW)) rq ();
    rv_iopmp_arb_tl_if  #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW)) tb_tl ();

    rv_iopmp_tl_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SID_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req(rq), .tl(tb_tl), .busy_o(busy), .timeout_o(tmo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle with requester g expected to win.
    task automatic serve(input int g, input int wait_n, input logic allow);
        logic [63:0] exp_addr;
        exp_addr = rq.req_addr_i[g];
        #2;
        chk($sformatf("ready_g%0d", g), 64'(rq.req_ready_o), 64'(1) << g);
        step();
        rq.req_valid_i[g] = 1'b0;
        tb_tl.tl_ready_i = 1'b1;
        #2;
        chk("issue_en", 64'(tb_tl.tl_transaction_en_o), 64'd1);
        chk("issue_addr", tb_tl.tl_addr_o, exp_addr);
        step();
        tb_tl.tl_ready_i = 1'b0;
        repeat (wait_n) step();
        tb_tl.tl_valid_i = 1'b1;
        tb_tl.tl_allow_i = allow;
        step();
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;
        #2;
        chk($sformatf("rsp_valid_g%0d", g), 64'(rq.rsp_valid_o), 64'(1) << g);
        chk("rsp_allow", 64'(rq.rsp_allow_o), 64'(allow));
        chk("rsp_timeout", 64'(tmo), 64'd0);
        step();
        #2;
        chk("idle_rsp_valid", 64'(rq.rsp_valid_o), 64'd0);
        chk("idle_rsp_allow", 64'(rq.rsp_allow_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "tb watchdog expired");
    end

    initial begin
        rq.req_valid_i = '0;
        for (int i = 0; i < NR; i++) begin
            rq.req_addr_i[i]      = 64'h1000 * (i + 1);
            rq.req_num_bytes_i[i] = 4'd8;
            rq.req_sid_i[i]       = 8'(i + 1);
            rq.req_access_i[i]    = ACCESS_READ;
        end
        tb_tl.tl_ready_i = 1'b0;
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;

        // Reset state
        step();
        step();
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(rq.req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(rq.rsp_valid_o), 64'd0);
        chk("rst_tl_en", 64'(tb_tl.tl_transaction_en_o), 64'd0);
        chk("rst_tl_addr", tb_tl.tl_addr_o, 64'd0);
        chk("rst_tl_access", 64'(tb_tl.tl_access_o), 64'(ACCESS_NONE));
        chk("rst_timeout", 64'(tmo), 64'd0);
        rst = 1'b0;
        step();

        // T1: single read from req0, verdict in the third WAIT cycle
        rq.req_addr_i[0]   = 64'h8000_0000;
        rq.req_sid_i[0]    = 8'h05;
        rq.req_access_i[0] = ACCESS_READ;
        rq.req_valid_i     = 4'b0001;
        serve(0, 2, 1'b1);

        // T2: all four from reset, then req0+req2 after last grant 3
        rst = 1'b1;
        step();
        rst = 1'b0;
        rq.req_valid_i = 4'b1111;
        serve(0, 0, 1'b1);
        serve(1, 1, 1'b0);
        serve(2, 0, 1'b1);
        serve(3, 0, 1'b1);
        rq.req_valid_i = 4'b0101;
        serve(0, 0, 1'b1);
        serve(2, 0, 1'b1);

        // T3: ISSUE held 5 cycles while TL not ready
        rq.req_addr_i[1]      = 64'h1234_5678_9ABC_DEF0;
        rq.req_num_bytes_i[1] = 4'd4;
        rq.req_sid_i[1]       = 8'hA5;
        rq.req_access_i[1]    = ACCESS_WRITE;
        rq.req_valid_i        = 4'b0010;
        #2;
        chk("t3_ready", 64'(rq.req_ready_o), 64'b0010);
        step();
        rq.req_valid_i   = 4'b0000;
        rq.req_addr_i[1] = 64'hDEAD_BEEF_0000_0000;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("t3_tl_en", 64'(tb_tl.tl_transaction_en_o), 64'd1);
            chk("t3_tl_addr", tb_tl.tl_addr_o, 64'h1234_5678_9ABC_DEF0);
            step();
        end
        #2;
        chk("t3_tl_sid", 64'(tb_tl.tl_sid_o), 64'hA5);
        chk("t3_tl_nb", 64'(tb_tl.tl_num_bytes_o), 64'd4);
        chk("t3_tl_access", 64'(tb_tl.tl_access_o), 64'(ACCESS_WRITE));
        tb_tl.tl_ready_i = 1'b1;
        step();
        tb_tl.tl_ready_i = 1'b0;
        #2;
        chk("t3_wait_en", 64'(tb_tl.tl_transaction_en_o), 64'd0);
        chk("t3_wait_busy", 64'(busy), 64'd1);
        tb_tl.tl_valid_i = 1'b1;
        tb_tl.tl_allow_i = 1'b1;
        step();
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;
        #2;
        chk("t3_rsp_valid", 64'(rq.rsp_valid_o), 64'b0010);
        chk("t3_rsp_allow", 64'(rq.rsp_allow_o), 64'd1);
        step();

        // T4: TL silent, watchdog denies after 64 WAIT cycles
        rq.req_valid_i = 4'b1000;
        #2;
        chk("t4_ready", 64'(rq.req_ready_o), 64'b1000);
        step();
        rq.req_valid_i   = 4'b0000;
        tb_tl.tl_ready_i = 1'b1;
        step();
        tb_tl.tl_ready_i = 1'b0;
        tb_tl.tl_allow_i = 1'b1;
        repeat (63) step();
        #2;
        chk("t4_wait64_rsp", 64'(rq.rsp_valid_o), 64'd0);
        chk("t4_wait64_tmo", 64'(tmo), 64'd0);
        chk("t4_wait64_busy", 64'(busy), 64'd1);
        step();
        #2;
        chk("t4_rsp_valid", 64'(rq.rsp_valid_o), 64'b1000);
        chk("t4_rsp_allow", 64'(rq.rsp_allow_o), 64'd0);
        chk("t4_timeout", 64'(tmo), 64'd1);
        step();
        tb_tl.tl_valid_i = 1'b1;
        #2;
        chk("t4_late_rsp", 64'(rq.rsp_valid_o), 64'd0);
        chk("t4_late_busy", 64'(busy), 64'd0);
        chk("t4_late_tmo", 64'(tmo), 64'd0);
        step();
        #2;
        chk("t4_late_rsp2", 64'(rq.rsp_valid_o), 64'd0);
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;

        // T5: explicit deny, then verdict arriving on the timeout cycle
        rq.req_valid_i = 4'b0100;
        serve(2, 0, 1'b0);
        rq.req_valid_i = 4'b0001;
        #2;
        chk("t5_ready", 64'(rq.req_ready_o), 64'b0001);
        step();
        rq.req_valid_i   = 4'b0000;
        tb_tl.tl_ready_i = 1'b1;
        step();
        tb_tl.tl_ready_i = 1'b0;
        repeat (63) step();
        tb_tl.tl_valid_i = 1'b1;
        tb_tl.tl_allow_i = 1'b1;
        step();
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;
        #2;
        chk("t5_race_rsp", 64'(rq.rsp_valid_o), 64'b0001);
        chk("t5_race_allow", 64'(rq.rsp_allow_o), 64'd1);
        chk("t5_race_tmo", 64'(tmo), 64'd0);
        step();

        // T6: reset while waiting aborts silently, req0 wins next
        rq.req_valid_i = 4'b0010;
        #2;
        chk("t6_ready", 64'(rq.req_ready_o), 64'b0010);
        step();
        rq.req_valid_i   = 4'b0000;
        tb_tl.tl_ready_i = 1'b1;
        step();
        tb_tl.tl_ready_i = 1'b0;
        step();
        rst = 1'b1;
        tb_tl.tl_valid_i = 1'b1;
        tb_tl.tl_allow_i = 1'b1;
        step();
        rst = 1'b0;
        tb_tl.tl_valid_i = 1'b0;
        tb_tl.tl_allow_i = 1'b0;
        #2;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_rsp", 64'(rq.rsp_valid_o), 64'd0);
        chk("t6_tl_en", 64'(tb_tl.tl_transaction_en_o), 64'd0);
        chk("t6_tl_addr", tb_tl.tl_addr_o, 64'd0);
        chk("t6_tl_access", 64'(tb_tl.tl_access_o), 64'(ACCESS_NONE));
        step();
        #2;
        chk("t6_rsp2", 64'(rq.rsp_valid_o), 64'd0);
        rq.req_valid_i = 4'b0011;
        serve(0, 0, 1'b1);
        rq.req_valid_i = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
